my_test_ahb_reg_master: RTL
===========================

# my_test_ahb_reg_master

Single-outstanding AHB-Lite initiator that turns a simple command/response handshake into 32-bit register read and write transfers. It drives the AHB side of the team's generated `*_ahb_regs_top` register blocks. It sits between a local controller or sequencer and the register block's `hsel`/`htrans`/`haddr`/`hwdata` port. It handles wait states, error responses, unaligned-address rejection and a wait-state timeout.

## Interface
Parameters:
- `ADDR_WIDTH`, 8, width of `cmd_addr`/`haddr`; matches the register block's `ADDR_WIDTH`.
- `TIMEOUT`, 16, maximum data-phase cycles with `hready`=0 before abort; must be ≥2.

Ports:
- `RegClk` in 1: the single clock; all logic rises on it.
- `RegReset_n` in 1: reset, asynchronous, active-low.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: command accepted when both are high.
- `cmd_write` in 1: 1 = write, 0 = read.
- `cmd_addr` in ADDR_WIDTH: byte address.
- `cmd_wdata` in 32: write data.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: response consumed when both are high.
- `rsp_rdata` out 32: read data; 0 for writes and errors.
- `rsp_err` out 1: slave ERROR, unaligned address, or timeout.
- `rsp_timeout` out 1: error was caused by a timeout.
- `hsel` out 1, `hwrite` out 1, `htrans` out 2, `hsize` out 3, `hburst` out 3, `haddr` out ADDR_WIDTH, `hwdata` out 32: AHB master outputs.
- `hrdata` in 32, `hresp` in 2, `hready` in 1: AHB slave responses.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP.
- IDLE: `cmd_ready`=1. On handshake, register write/addr/wdata.
  - If `cmd_addr[1:0]`≠0, go to RESP with `rsp_err`=1 and `rsp_rdata`=0. No bus transfer is issued.
  - Otherwise go to ADDR.
- ADDR, one cycle: `hsel`=1, `htrans`=2'b10 (NONSEQ), `haddr`=command address, `hwrite`=command write bit. Next state is DATA.
- DATA: `hsel`=0, `htrans`=2'b00, `hwdata`=command data (held for the whole phase). Wait counter starts at 0.
  - `hready`=1: capture `hrdata` (reads only), set err=`hresp[0]`, go to RESP.
  - `hready`=0: increment the counter. When the counter reaches TIMEOUT-1 with `hready` still 0, go to RESP with err=1, timeout=1, rdata=0.
- RESP: `rsp_valid`=1. Outputs stay stable until `rsp_ready`=1, then go to IDLE. Exactly one command is outstanding at any time.
- Fixed outputs: `hsize`=3'b010 and `hburst`=3'b000 always.
- Error responses always return `rsp_rdata`=0, including a read that gets `hresp`=01.
- `hwdata` is 0 outside DATA.
- Reset values: state IDLE, `cmd_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `rsp_timeout`=0, `hsel`=0, `htrans`=00, `hwrite`=0, `haddr`=0, `hwdata`=0.
- Reset mid-transfer: return to the reset values immediately. The in-flight response is discarded.

## Timing
- Command handshake at edge T:
  - T..T+1 is the address phase.
  - T+1..T+2 is the data phase when there are no waits; `hready` is sampled at edge T+2.
  - `rsp_valid` is high from T+2 to T+3.
- Each wait cycle adds 1 cycle of latency.
- Unaligned command: `rsp_valid` high in the cycle after the handshake.
- `cmd_ready` is low from the handshake until the response handshake completes. The next command can be accepted in the cycle after the response handshake. Minimum throughput is one transfer per 4 cycles.
- All outputs are registered, with no combinational path from inputs to outputs.

## Structure
- Shared package `ahb_reg_pkg` holds:
  - `HTRANS_IDLE` and `HTRANS_NONSEQ`, `HSIZE_WORD`, `HBURST_SINGLE`, `HRESP_OKAY` and `HRESP_ERROR`.
  - The FSM state enum `ahb_mst_state_t`.
- Single module; no sub-module is needed. The timeout counter is `$clog2(TIMEOUT)` bits wide and stays inline.

## Test plan
- Write 0x0/0x00000ABC, then read 0x0 against `my_test_ahb_regs_top` -> `rsp_rdata`=0x00000ABC, `rsp_err`=0. The first response arrives 2 cycles after the command handshake.
- Read 0xC after reset -> 0x0001E240. Read 0x4 -> 0x070004D2.
- Read 0x10 (unmapped) -> `rsp_err`=1, `rsp_timeout`=0, `rsp_rdata`=0. `htrans` NONSEQ was issued.
- Command at 0x6 -> `rsp_err`=1 one cycle later, and `htrans` stays 00 throughout.
- With a bus model, hold `hready`=0 for 3 cycles -> `hwdata` is stable throughout and the response arrives 3 cycles later. Hold `hready`=0 for 20 cycles with TIMEOUT=16 -> `rsp_err`=1, `rsp_timeout`=1, 16 cycles after DATA entry.
- Hold `rsp_ready`=0 for 5 cycles -> response stable and `cmd_ready`=0. Then assert `RegReset_n`=0 in DATA -> all outputs immediately at reset values.

Source files
------------

// File: rtl/ahb_reg_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package   : ahb_reg_pkg                                              |
// | Purpose   : AHB-Lite encodings and FSM state type shared by the      |
// |             register-block initiator and its neighbours.             |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
package ahb_reg_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;
   localparam logic [1:0] HRESP_ERROR   = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } ahb_mst_state_t;

endpackage
`default_nettype wire

// File: rtl/my_test_ahb_reg_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : my_test_ahb_reg_master                                   |
// | Purpose   : Single-outstanding AHB-Lite initiator turning a local    |
// |             command/response handshake into 32-bit register reads    |
// |             and writes. Handles wait states, ERROR responses,        |
// |             unaligned-address rejection and a wait-state timeout.    |
// | Ports     : RegClk, RegReset_n (async, active-low)                   |
// |             cmd_*  : command request (valid/ready, write, addr, data)|
// |             rsp_*  : response (valid/ready, rdata, err, timeout)     |
// |             h*     : AHB-Lite master outputs / slave responses       |
// | Revision  : 1.0  initial release                                     |
// +----------------------------------------------------------------------+
module my_test_ahb_reg_master
   import ahb_reg_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int TIMEOUT    = 16   // must be >= 2
) (
   input  logic                  RegClk,
   input  logic                  RegReset_n,
   // command side
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [31:0]           cmd_wdata,
   // response side
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rdata,
   output logic                  rsp_err,
   output logic                  rsp_timeout,
   // AHB-Lite master
   output logic                  hsel,
   output logic                  hwrite,
   output logic [1:0]            htrans,
   output logic [2:0]            hsize,
   output logic [2:0]            hburst,
   output logic [ADDR_WIDTH-1:0] haddr,
   output logic [31:0]           hwdata,
   input  logic [31:0]           hrdata,
   input  logic [1:0]            hresp,
   input  logic                  hready
);

   localparam int                 c_CNT_W     = $clog2(TIMEOUT);
   localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(TIMEOUT - 1);

   ahb_mst_state_t     r_state;
   logic [c_CNT_W-1:0] r_wait_cnt;
   logic [31:0]        r_wdata;

   // Only OKAY/ERROR exist on this bus; the upper response bit carries nothing.
   logic w_unused;
   assign w_unused = hresp[1];

   assign hsize  = HSIZE_WORD;
   assign hburst = HBURST_SINGLE;

   always_ff @(posedge RegClk or negedge RegReset_n) begin
      if (!RegReset_n) begin
         r_state     <= ST_IDLE;
         r_wait_cnt  <= '0;
         r_wdata     <= '0;
         cmd_ready   <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         rsp_err     <= 1'b0;
         rsp_timeout <= 1'b0;
         hsel        <= 1'b0;
         htrans      <= HTRANS_IDLE;
         hwrite      <= 1'b0;
         haddr       <= '0;
         hwdata      <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // cmd_ready is always high here, so cmd_valid alone is the handshake
               if (cmd_valid) begin
                  cmd_ready <= 1'b0;
                  r_wdata   <= cmd_wdata;
                  if (cmd_addr[1:0] != 2'b00) begin
                     // Unaligned: answer with an error without touching the bus
                     r_state     <= ST_RESP;
                     rsp_valid   <= 1'b1;
                     rsp_err     <= 1'b1;
                     rsp_timeout <= 1'b0;
                     rsp_rdata   <= '0;
                  end else begin
                     r_state <= ST_ADDR;
                     hsel    <= 1'b1;
                     htrans  <= HTRANS_NONSEQ;
                     haddr   <= cmd_addr;
                     hwrite  <= cmd_write;
                  end
               end
            end

            ST_ADDR: begin
               r_state    <= ST_DATA;
               hsel       <= 1'b0;
               htrans     <= HTRANS_IDLE;
               hwdata     <= r_wdata;
               r_wait_cnt <= '0;
            end

            ST_DATA: begin
               if (hready) begin
                  r_state     <= ST_RESP;
                  hwdata      <= '0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= hresp[0];
                  rsp_timeout <= 1'b0;
                  // hwrite is still held from the address phase
                  rsp_rdata   <= (!hwrite && !hresp[0]) ? hrdata : 32'h0;
               end else if (r_wait_cnt == c_WAIT_LAST) begin
                  // TIMEOUT wait cycles seen: abandon the transfer
                  r_state     <= ST_RESP;
                  hwdata      <= '0;
                  rsp_valid   <= 1'b1;
                  rsp_err     <= 1'b1;
                  rsp_timeout <= 1'b1;
                  rsp_rdata   <= '0;
               end else begin
                  r_wait_cnt <= r_wait_cnt + 1'b1;
               end
            end

            ST_RESP: begin
               if (rsp_ready) begin
                  r_state     <= ST_IDLE;
                  cmd_ready   <= 1'b1;
                  rsp_valid   <= 1'b0;
                  rsp_rdata   <= '0;
                  rsp_err     <= 1'b0;
                  rsp_timeout <= 1'b0;
               end
            end

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
